// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: instruction sequencer wrapped around the 4-bit combinational ALU.
// Accepts {opcode, immediate} over valid/ready and runs one ALU step per
// instruction against the accumulator. The captured result is returned over
// valid/ready.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for an instruction; ALU select parked at pass-A
// EXEC  | ALU driven with op/acc/imm; result captured at closing edge
// DONE  | result presented on res_valid until res_ready
module alu_seq_ctrl #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [6:0]        in_instr,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_s,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] acc,
    output logic              flag_c,
    output logic              flag_z,
    output logic              illegal,
    output logic [CNT_W-1:0]  icount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        op;
    logic [DATA_W-1:0] imm;
    logic              op_legal;
    logic              carry_used;
    logic              accept;

    // Opcodes above NAND are rejected; carry is only meaningful for SUB/ADD.
    assign op_legal   = (op <= 3'b100);
    assign carry_used = (op == 3'b001) || (op == 3'b011);
    assign accept     = in_valid && in_ready;

    assign alu_a = acc;
    assign alu_b = imm;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the state-decoded outputs (in_ready, alu_s).
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        alu_s      = 3'b000;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_next = EXEC;
                    end
                end
                EXEC: begin
                    alu_s      = op_legal ? op : 3'b000;
                    state_next = DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Instruction latch, result capture, flags, counter and result-valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op        <= 3'b000;
            imm       <= '0;
            acc       <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            illegal   <= 1'b0;
            icount    <= '0;
            res_valid <= 1'b0;
        end else if (clr) begin
            acc       <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            illegal   <= 1'b0;
            icount    <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= (state_next == DONE);
            if (state == IDLE && accept) begin
                op  <= in_instr[6:4];
                imm <= in_instr[DATA_W-1:0];
            end
            if (state == EXEC) begin
                icount <= icount + CNT_W'(1);
                if (op_legal) begin
                    acc    <= alu_y;
                    flag_z <= alu_zero;
                    flag_c <= carry_used ? alu_carry : 1'b0;
                end else begin
                    illegal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with a behavioural ALU
// attached and a scoreboard of expected results pushed on each accept.
module tb_alu_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       in_valid;
    logic [6:0] in_instr;
    logic       in_ready;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_s;
    logic [3:0] alu_y;
    logic       alu_carry;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       illegal;
    logic [7:0] icount;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] acc;
        logic       c;
        logic       z;
        logic       ill;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];

    // Reference model state.
    logic [3:0] m_acc;
    logic       m_c;
    logic       m_z;
    logic       m_ill;
    logic [7:0] m_cnt;

    // When set, the ALU model drives carry=1 on ops where carry is undefined.
    logic force_c;

    alu_seq_ctrl #(.DATA_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
        .illegal(illegal), .icount(icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU.
    logic [4:0] alu_t;
    always_comb begin
        alu_t     = 5'd0;
        alu_y     = alu_a;
        alu_carry = 1'b0;
        case (alu_s)
            3'b000: begin alu_y = alu_a; alu_carry = force_c; end
            3'b001: begin
                alu_t = {1'b0, alu_a} - {1'b0, alu_b};
                alu_y = alu_t[3:0]; alu_carry = alu_t[4];
            end
            3'b010: begin alu_y = alu_b; alu_carry = force_c; end
            3'b011: begin
                alu_t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y = alu_t[3:0]; alu_carry = alu_t[4];
            end
            3'b100: begin alu_y = ~(alu_a & alu_b); alu_carry = force_c; end
            default: begin alu_y = alu_a; alu_carry = force_c; end
        endcase
        alu_zero = (alu_y == 4'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 4'd0; m_c = 1'b0; m_z = 1'b0; m_ill = 1'b0; m_cnt = 8'd0;
    endtask

    // Present one instruction, wait for acceptance, push the expected result.
    task automatic issue(input logic [6:0] instr);
        int n;
        logic [2:0] o;
        logic [3:0] im;
        logic [4:0] s;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = ~instr;
        o  = instr[6:4];
        im = instr[3:0];
        case (o)
            3'b000: begin m_c = 1'b0; m_z = (m_acc == 4'd0); end
            3'b001: begin m_c = (m_acc < im); m_acc = m_acc - im; m_z = (m_acc == 4'd0); end
            3'b010: begin m_acc = im; m_c = 1'b0; m_z = (m_acc == 4'd0); end
            3'b011: begin s = {1'b0, m_acc} + {1'b0, im}; m_acc = s[3:0]; m_c = s[4]; m_z = (m_acc == 4'd0); end
            3'b100: begin m_acc = ~(m_acc & im); m_c = 1'b0; m_z = (m_acc == 4'd0); end
            default: m_ill = 1'b1;
        endcase
        m_cnt = m_cnt + 8'd1;
        e.acc = m_acc; e.c = m_c; e.z = m_z; e.ill = m_ill; e.cnt = m_cnt;
        q.push_back(e);
        chk("exec_in_ready", in_ready, 0);
        chk("exec_alu_s", alu_s, (o <= 3'b100) ? o : 3'b000);
        chk("exec_alu_b", alu_b, im);
    endtask

    // Wait for the result, check latency and pop/compare against the scoreboard.
    task automatic collect();
        int n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 10);
        chk("res_latency", n, 2);
        chk("res_valid", res_valid, 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("acc", acc, e.acc);
            chk("flag_c", flag_c, e.c);
            chk("flag_z", flag_z, e.z);
            chk("illegal", illegal, e.ill);
            chk("icount", icount, e.cnt);
        end
        if (res_ready) begin
            @(negedge clk);
            chk("res_valid_pulse_end", res_valid, 0);
        end
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_instr = 7'd0;
        res_ready = 1'b1; force_c = 1'b0;
        model_clear();
        #1;
        chk("rst_acc", acc, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_s", alu_s, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_icount", icount, 0);
        chk("rst_illegal", illegal, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // LOAD then ADD with carry out.
        issue(7'b010_1010); collect();
        issue(7'b011_0111); collect();

        // SUB with borrow, then SUB to zero.
        issue(7'b010_0011); collect();
        issue(7'b001_0101); collect();
        issue(7'b001_1110); collect();

        // NAND to zero while the ALU claims a carry.
        issue(7'b010_1111); collect();
        force_c = 1'b1;
        issue(7'b100_1111); collect();
        issue(7'b010_1001); collect();
        force_c = 1'b0;

        // Illegal opcode, then a legal op keeps illegal sticky.
        issue(7'b010_0101); collect();
        issue(7'b110_0001); collect();
        issue(7'b011_0001); collect();

        // Back-pressure: res_ready low for 5 cycles.
        res_ready = 1'b0;
        issue(7'b011_0010); collect();
        in_valid = 1'b1;
        in_instr = 7'b010_1100;
        repeat (5) begin
            chk("hold_res_valid", res_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_icount", icount, m_cnt);
            @(negedge clk);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("release_res_valid", res_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_acc", acc, m_acc);
        issue(7'b011_0001); collect();

        // clr while in DONE, then clr blocks an IDLE accept.
        res_ready = 1'b0;
        issue(7'b010_0111); collect();
        clr = 1'b1;
        in_valid = 1'b1;
        in_instr = 7'b010_0001;
        #1;
        chk("clr_in_ready", in_ready, 0);
        @(negedge clk);
        model_clear();
        chk("clr_acc", acc, 0);
        chk("clr_icount", icount, 0);
        chk("clr_res_valid", res_valid, 0);
        chk("clr_illegal", illegal, 0);
        chk("clr_idle_blocked", in_ready, 0);
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_no_accept", in_ready, 1);
        chk("clr_no_accept_alu_s", alu_s, 0);
        res_ready = 1'b1;
        @(negedge clk);

        // Async reset while in EXEC discards the instruction.
        issue(7'b010_0110); collect();
        issue(7'b011_0011);
        #1;
        reset = 1'b1;
        #1;
        q.delete();
        model_clear();
        chk("arst_acc", acc, 0);
        chk("arst_icount", icount, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_alu_s", alu_s, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_post_icount", icount, 0);
        chk("arst_post_res_valid", res_valid, 0);

        // Counter wrap: 255 NOPs then one more.
        for (int i = 0; i < 255; i++) begin
            issue(7'b000_0000); collect();
        end
        chk("cnt_255", icount, 255);
        issue(7'b000_0000); collect();
        chk("cnt_wrap", icount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer that drives the team's 4-bit combinational ALU (ops: 000 pass A, 001 A-B, 010 pass B, 011 A+B, 100 NAND).
- Accepts 7-bit instructions (3-bit opcode + 4-bit immediate) over a valid/ready handshake and feeds the ALU with A=accumulator, B=immediate, S=opcode.
- Captures Y, carry and zero into registers and returns the result over a valid/ready handshake.
- Sits between an instruction source (switches/ROM stepper) and the ALU instance.

Parameters:
- DATA_W, 4, datapath width; fixed at 4 to match the ALU, other values unsupported.
- CNT_W, 8, width of the executed-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of accumulator, flags, counter and FSM.
- in_valid  in  1  instruction present.
- in_instr  in  7  [6:4] opcode, [3:0] immediate.
- in_ready  out  1  controller can accept an instruction.
- alu_a  out  4  ALU operand A; always equals acc.
- alu_b  out  4  ALU operand B; equals imm register.
- alu_s  out  3  ALU select.
- alu_y  in  4  ALU result.
- alu_carry  in  1  ALU carry_out.
- alu_zero  in  1  ALU zero.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- acc  out  4  accumulator value.
- flag_c  out  1  registered carry/borrow.
- flag_z  out  1  registered zero.
- illegal  out  1  sticky: an opcode 101–111 was received.
- icount  out  CNT_W  instructions completed.

Behaviour:
- Reset (async, any state): FSM=IDLE; acc=0, imm=0, op=000, flag_c=0, flag_z=0, illegal=0, icount=0; res_valid=0, in_ready=1. ALU outputs follow immediately: alu_a=0, alu_b=0, alu_s=000.
- FSM states are IDLE, EXEC and DONE.
- IDLE:
  - in_ready=1, alu_s=000.
  - On in_valid&in_ready: latch op=in_instr[6:4], imm=in_instr[3:0]; go to EXEC.
- EXEC (exactly 1 cycle):
  - in_ready=0. For op ≤ 100, alu_s=op. For an illegal op, alu_s=000.
  - At the closing edge, for legal ops: acc<=alu_y and flag_z<=alu_zero.
  - flag_c<=alu_carry only for op 001/011. For 000/010/100, flag_c<=0; ALU carry is ignored because it is undefined for NAND.
  - For ops 101–111: acc and flags are unchanged and illegal<=1.
  - In all cases, icount<=icount+1 (wraps to 0 after 2^CNT_W−1). Go to DONE.
- DONE:
  - res_valid=1, in_ready=0. acc and flags hold.
  - On res_ready, go to IDLE; res_valid drops the next cycle.
  - res_valid stays high indefinitely while res_ready=0.
- Latency: instruction accepted at edge T → acc/flags valid and res_valid=1 after edge T+1. Minimum issue interval is 3 cycles; with res_ready held at 1 there is one instruction every 3 cycles.
- Arithmetic semantics (from the ALU, recorded here for checking):
  - ADD: flag_c = bit 4 of acc+imm.
  - SUB: flag_c = 1 iff acc < imm (borrow); acc = (acc−imm) mod 16.
  - zero reflects the 4-bit result only.
- clr: synchronous, highest priority in every state. It zeroes acc, flags, illegal and icount, returns to IDLE, and drops res_valid. Any instruction presented in the same cycle is not accepted (in_ready is forced 0 while clr=1).
- in_instr is sampled only on the accept edge; changes afterwards have no effect.
- reset mid-EXEC or mid-DONE: the result is discarded and no icount increment occurs.
- Outputs acc, flag_c, flag_z, illegal, icount and res_valid are all registered; in_ready and alu_s are decoded from state.

Test Plan:
- Reset then LOAD 010_1010, ADD 011_0111 with res_ready=1 → after LOAD acc=1010; after ADD acc=0001, flag_c=1, flag_z=0, icount=2; res_valid pulses 1 cycle each, 2 cycles after accept.
- acc=0011, SUB 001_0101 → acc=1110, flag_c=1 (borrow); then SUB 001_1110 → acc=0000, flag_z=1, flag_c=0.
- acc=1111, NAND 100_1111 → acc=0000, flag_z=1, flag_c=0 even with alu_carry forced 1 by the bench.
- Opcode 110_0001 with acc=0101 → acc stays 0101, flags unchanged, illegal=1 sticky, icount increments. A following legal op leaves illegal=1 until clr.
- Hold res_ready=0 for 5 cycles after a result → res_valid stays 1, in_ready stays 0 and new in_valid is ignored. Release → IDLE, next instruction accepted.
- Assert clr in DONE and, separately, assert async reset mid-EXEC → acc=0, icount=0, res_valid=0, IDLE next cycle (reset: immediately). Preload icount to 255 by 255 NOPs (000), one more → icount=0.
